// File: rtl/inst_mem_loader.sv
// Byte-stream boot loader: receives a length-prefixed program image one byte
// at a time, packs bytes little-endian into 32-bit words and writes them into
// the instruction memory, holding the CPU until the image is complete.
// Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [LEN_W-1:0]  word_count
);

  localparam int unsigned Capacity = 2 ** (ADDR_W - 2);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCheck, StDone, StError
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StDone, StError
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] len_full;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_q;
  logic        accept;
  logic        enter_len_lo;
  logic        words_done;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept       = rx_valid & rx_ready;
  assign len_full     = {rx_byte, len_q[7:0]};
  assign enter_len_lo = (state_d == StLenLo) && (state_q != StLenLo);
  // word_count already holds the incremented value during the strobe cycle
  assign words_done   = (word_count == LEN_W'(len_q));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    rx_ready  = 1'b0;
    load_done = 1'b0;
    load_err  = 1'b0;
    cpu_hold  = 1'b1;
    case (state_q)
      StIdle: begin
        if (start) state_d = StLenLo;
      end
      StLenLo: begin
        rx_ready = 1'b1;
        if (accept) state_d = StLenHi;
      end
      StLenHi: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (32'(len_full) > Capacity) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        // Stop taking bytes once the final word has been handed to the strobe
        rx_ready = !words_done;
        if (words_done) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        rx_ready = 1'b1;
        if (accept) state_d = (rx_byte == csum_q) ? StDone : StError;
      end
`endif
      StDone: begin
        load_done = 1'b1;
        cpu_hold  = 1'b0;
        if (start) state_d = StLenLo;
      end
      StError: begin
        load_err = 1'b1;
        if (start) state_d = StLenLo;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: length capture, word assembly and memory write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (enter_len_lo) begin
        word_count <= '0;
        byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end else if (accept) begin
        case (state_q)
          StLenLo: len_q[7:0]  <= rx_byte;
          StLenHi: len_q[15:8] <= rx_byte;
          StData: begin
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ rx_byte;
`endif
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= rx_byte;
              2'd1: word_q[15:8]  <= rx_byte;
              2'd2: word_q[23:16] <= rx_byte;
              default: begin
                mem_we     <= 1'b1;
                mem_wdata  <= {rx_byte, word_q};
                mem_addr   <= ADDR_W'({word_count, 2'b00});
                word_count <= word_count + LEN_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader; checksum vectors are enabled with
// LOADER_CHECKSUM_EN, matching the design build.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] word_count;

  int vectors = 0;
  int errors  = 0;
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];

  inst_mem_loader #(.ADDR_W(12), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Capture every write strobe mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one byte, optionally after a random idle gap, and hold it until taken
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n = 0;
    repeat ($urandom_range(0, gap_max)) begin
      @(negedge clk); rx_valid = 1'b0; rx_byte = 8'hFF;
    end
    @(negedge clk); rx_valid = 1'b1; rx_byte = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_byte = 8'hFF;
  endtask

  // Bytes are listed most-significant first so the literal reads in stream order
  task automatic send_bytes(input logic [127:0] data, input int n, input int gap_max);
    for (int i = 0; i < n; i++) send_byte(data[8*(n-1-i) +: 8], gap_max);
  endtask

  task automatic send_csum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    send_byte(b, 0);
`else
    if (b === 8'hxx) $display("unused checksum byte");
`endif
  endtask

  task automatic wait_settle();
    int n = 0;
    while (!(load_done || load_err) && n < 40) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (2) @(negedge clk);
    // Reset values
    check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    check_eq("rst_addr_data", 32'(mem_addr) | mem_wdata | 32'(word_count), 32'd0);
    reset = 1'b1;

    // Test 1: two-word image at full rate, with latency check
    pulse_start();
    send_bytes(80'h02_00_13_05_A0_00_93_05_10_00, 10, 0);
    @(negedge clk);
    check_eq("t1_we_pulse", 32'(mem_we), 32'd1);
    check_eq("t1_done_early", 32'(load_done), 32'd0);
    @(negedge clk);
    check_eq("t1_we_single", 32'(mem_we), 32'd0);
`ifndef LOADER_CHECKSUM_EN
    check_eq("t1_done_latency", 32'(load_done), 32'd1);
`endif
    send_csum(8'h30);
    wait_settle();
    check_eq("t1_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check_eq("t1_addr0", 32'(wr_addr[0]), 32'h0);
      check_eq("t1_data0", wr_data[0], 32'h00A00513);
      check_eq("t1_addr1", 32'(wr_addr[1]), 32'h4);
      check_eq("t1_data1", wr_data[1], 32'h00100593);
    end
    check_eq("t1_word_count", 32'(word_count), 32'd2);
    check_eq("t1_done", 32'(load_done), 32'd1);
    check_eq("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    check_eq("t1_rx_ready", 32'(rx_ready), 32'd0);

    // Test 2: empty image
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check_eq("t2_hold_on_start", 32'(cpu_hold), 32'd1);
    check_eq("t2_done_cleared", 32'(load_done), 32'd0);
    send_bytes(16'h00_00, 2, 0);
    send_csum(8'h00);
    wait_settle();
    check_eq("t2_done", 32'(load_done), 32'd1);
    check_eq("t2_word_count", 32'(word_count), 32'd0);
    check_eq("t2_nwr", wr_addr.size(), 0);

    // Test 3: oversize length (0x401 > 1024 words)
    pulse_start();
    send_bytes(16'h01_04, 2, 0);
    wait_settle();
    check_eq("t3_err", 32'(load_err), 32'd1);
    check_eq("t3_done", 32'(load_done), 32'd0);
    check_eq("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("t3_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t3_nwr", wr_addr.size(), 0);

    // Test 4: three words with random valid gaps
    pulse_start();
    check_eq("t4_err_cleared", 32'(load_err), 32'd0);
    send_bytes(112'h03_00_13_05_A0_00_93_05_10_00_EF_BE_AD_DE, 14, 3);
    send_csum(8'h12);
    wait_settle();
    check_eq("t4_nwr", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check_eq("t4_addr0", 32'(wr_addr[0]), 32'h0);
      check_eq("t4_data0", wr_data[0], 32'h00A00513);
      check_eq("t4_addr1", 32'(wr_addr[1]), 32'h4);
      check_eq("t4_data1", wr_data[1], 32'h00100593);
      check_eq("t4_addr2", 32'(wr_addr[2]), 32'h8);
      check_eq("t4_data2", wr_data[2], 32'hDEADBEEF);
    end
    check_eq("t4_word_count", 32'(word_count), 32'd3);
    check_eq("t4_done", 32'(load_done), 32'd1);

    // Test 5: reset mid-load, then a fresh one-word load
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_bytes(64'h02_00_13_05_A0_00_93_05, 8, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_word_count", 32'(word_count), 32'd0);
    check_eq("t5_rst_hold_ready", {30'd0, cpu_hold, rx_ready}, 32'd2);
    check_eq("t5_rst_addr_data", 32'(mem_addr) | mem_wdata, 32'd0);
    check_eq("t5_rst_we_flags", {29'd0, mem_we, load_done, load_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_bytes(48'h01_00_78_56_34_12, 6, 0);
    send_csum(8'h08);
    wait_settle();
    check_eq("t5_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check_eq("t5_addr0", 32'(wr_addr[0]), 32'h0);
      check_eq("t5_data0", wr_data[0], 32'h12345678);
    end
    check_eq("t5_done", 32'(load_done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: bad checksum keeps the written word and the CPU held
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_bytes(56'h01_00_78_56_34_12_09, 7, 0);
    wait_settle();
    check_eq("t6_err", 32'(load_err), 32'd1);
    check_eq("t6_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("t6_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check_eq("t6_data0", wr_data[0], 32'h12345678);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
